// File: rtl/sdio_dma_rd.sv
// rtl/sdio_dma_rd.sv - read-DMA engine draining the SD receive ping-pong buffers into a byte stream
// One block per buffer; returns buf_free per drained buffer and pulses done_irq at transfer end.
module sdio_dma_rd #(
   parameter int BUF_BYTES = 512,
   parameter int AW        = 9,
   parameter int HOLDOFF   = 6
) (
   input  logic          sclk,
   input  logic          rstn,
   input  logic          srst,
   input  logic          start,
   input  logic [15:0]   blk_cnt,
   input  logic          dma_auto_start,
   input  logic          buf0_rd_rdy,
   input  logic          buf1_rd_rdy,
   input  logic          dat_done,
   output logic          buf_free,
   output logic          buf_rd_en,
   output logic          buf_rd_sel,
   output logic [AW-1:0] buf_rd_addr,
   input  logic [7:0]    buf_rd_data,
   output logic          m_valid,
   output logic [7:0]    m_data,
   input  logic          m_ready,
   output logic          busy,
   output logic          done_irq,
   output logic          short_xfer,
   output logic [15:0]   blk_done
);
   localparam int HW = (HOLDOFF < 2) ? 1 : $clog2(HOLDOFF + 1);

   typedef enum logic [2:0] {IDLE, WAIT_RDY, XFER, FREE, DONE} state_t;

   state_t        state;
   logic [15:0]   blk_total;
   logic          dat_done_seen;
   logic [HW-1:0] holdoff;
   logic [AW:0]   rd_left;
   logic [AW:0]   tx_left;
   logic          rd_pend;
   logic [7:0]    fifo [2];
   logic          wr_ptr;
   logic          rd_ptr;
   logic [1:0]    occ;
   logic          hs;
   logic          sel_rdy;
   logic [2:0]    inflight;

   assign m_valid  = (occ != 2'd0);
   assign m_data   = fifo[rd_ptr];
   assign hs       = m_valid & m_ready;
   assign sel_rdy  = buf_rd_sel ? buf1_rd_rdy : buf0_rd_rdy;
   assign inflight = {1'b0, occ} + {2'b0, rd_pend};
   // A byte leaving this cycle frees a slot, which keeps 1 byte/cycle with m_ready held high.
   assign buf_rd_en = (state == XFER) && (rd_left != '0) && (inflight < 3'd2 + {2'b0, hs});

   always_ff @(posedge sclk or negedge rstn) begin
      if (!rstn) begin
         state <= IDLE;         blk_total <= '0;     blk_done <= '0;
         short_xfer <= 1'b0;    dat_done_seen <= 1'b0;
         holdoff <= '0;         rd_left <= '0;       tx_left <= '0;
         buf_rd_addr <= '0;     buf_rd_sel <= 1'b0;  rd_pend <= 1'b0;
         fifo[0] <= '0;         fifo[1] <= '0;
         wr_ptr <= 1'b0;        rd_ptr <= 1'b0;      occ <= '0;
         buf_free <= 1'b0;      done_irq <= 1'b0;    busy <= 1'b0;
      end else if (srst) begin
         state <= IDLE;         blk_total <= '0;     blk_done <= '0;
         short_xfer <= 1'b0;    dat_done_seen <= 1'b0;
         holdoff <= '0;         rd_left <= '0;       tx_left <= '0;
         buf_rd_addr <= '0;     buf_rd_sel <= 1'b0;  rd_pend <= 1'b0;
         fifo[0] <= '0;         fifo[1] <= '0;
         wr_ptr <= 1'b0;        rd_ptr <= 1'b0;      occ <= '0;
         buf_free <= 1'b0;      done_irq <= 1'b0;    busy <= 1'b0;
      end else begin
         buf_free <= 1'b0;
         done_irq <= 1'b0;
         rd_pend  <= buf_rd_en;
         if (buf_rd_en) begin
            buf_rd_addr <= buf_rd_addr + AW'(1);
            rd_left     <= rd_left - (AW+1)'(1);
         end
         if (rd_pend) begin
            fifo[wr_ptr] <= buf_rd_data;
            wr_ptr       <= ~wr_ptr;
         end
         if (hs) begin
            rd_ptr  <= ~rd_ptr;
            tx_left <= tx_left - (AW+1)'(1);
         end
         occ <= occ + {1'b0, rd_pend} - {1'b0, hs};
         if (dat_done && state != IDLE)
            dat_done_seen <= 1'b1;

         case (state)
            IDLE: begin
               if (start || dma_auto_start) begin
                  state         <= WAIT_RDY;
                  busy          <= 1'b1;
                  blk_total     <= blk_cnt;
                  blk_done      <= '0;
                  short_xfer    <= 1'b0;
                  dat_done_seen <= 1'b0;
                  buf_rd_sel    <= 1'b0;
                  holdoff       <= '0;
               end
            end
            WAIT_RDY: begin
               if (holdoff != '0) begin
                  holdoff <= holdoff - HW'(1);
               end else if (sel_rdy) begin
                  state       <= XFER;
                  rd_left     <= (AW+1)'(BUF_BYTES);
                  tx_left     <= (AW+1)'(BUF_BYTES);
                  buf_rd_addr <= '0;
               end else if (dat_done_seen) begin
                  state      <= DONE;
                  short_xfer <= 1'b1;
                  done_irq   <= 1'b1;
               end
            end
            XFER: begin
               if (hs && tx_left == (AW+1)'(1)) begin
                  state    <= FREE;
                  buf_free <= 1'b1;
               end
            end
            FREE: begin
               blk_done   <= blk_done + 16'd1;
               buf_rd_sel <= ~buf_rd_sel;
               // Ready levels lag buf_free by the sync round trip; ignore them for a while.
               holdoff    <= HW'(HOLDOFF);
               if (blk_done + 16'd1 == blk_total) begin
                  state    <= DONE;
                  done_irq <= 1'b1;
               end else begin
                  state <= WAIT_RDY;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sdio_dma_rd.sv
// tb/tb_sdio_dma_rd.sv - randomized self-checking bench for sdio_dma_rd
// Buffers hold random bytes; the expected stream is the buffer contents in block order.
module tb_sdio_dma_rd;
   localparam int BUF  = 512;
   localparam int AW   = 9;
   localparam int HOLD = 6;

   logic          sclk, rstn, srst, start, dma_auto_start;
   logic          buf0_rd_rdy, buf1_rd_rdy, dat_done, m_ready;
   logic [15:0]   blk_cnt;
   logic [7:0]    buf_rd_data;
   logic          buf_free, buf_rd_en, buf_rd_sel, m_valid, busy, done_irq, short_xfer;
   logic [AW-1:0] buf_rd_addr;
   logic [7:0]    m_data;
   logic [15:0]   blk_done;

   sdio_dma_rd #(.BUF_BYTES(BUF), .AW(AW), .HOLDOFF(HOLD)) dut (
      .sclk(sclk), .rstn(rstn), .srst(srst), .start(start), .blk_cnt(blk_cnt),
      .dma_auto_start(dma_auto_start), .buf0_rd_rdy(buf0_rd_rdy), .buf1_rd_rdy(buf1_rd_rdy),
      .dat_done(dat_done), .buf_free(buf_free), .buf_rd_en(buf_rd_en), .buf_rd_sel(buf_rd_sel),
      .buf_rd_addr(buf_rd_addr), .buf_rd_data(buf_rd_data), .m_valid(m_valid), .m_data(m_data),
      .m_ready(m_ready), .busy(busy), .done_irq(done_irq), .short_xfer(short_xfer),
      .blk_done(blk_done)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   logic [7:0] mem0 [BUF];
   logic [7:0] mem1 [BUF];
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];
   bit         free_q [$];
   int         hs_cyc_q [$];
   int done_cnt = 0, done_cyc = 0, free_cyc = 0, rd_cnt = 0, hs_cnt = 0;
   int inflight = 0, stall_err = 0, ovf_err = 0;
   int first_rden = -1, first_valid = -1, first_addr = -1, rdy_cyc = 0;
   bit stall_prev = 0;
   logic [7:0] stall_data = 0;
   bit rand_ready = 0;
   bit rs_en = 0, rs_sel = 0;
   logic [AW-1:0] rs_addr = 0;

   initial begin
      sclk = 0;
      forever #5 sclk = ~sclk;
   end

   always @(posedge sclk) cyc++;

   // Buffer RAM: data valid for the whole cycle after a read strobe, garbage otherwise.
   always begin
      @(negedge sclk);
      rs_en = buf_rd_en; rs_sel = buf_rd_sel; rs_addr = buf_rd_addr;
      @(posedge sclk);
      #1;
      buf_rd_data = rs_en ? (rs_sel ? mem1[rs_addr] : mem0[rs_addr]) : 8'($urandom);
   end

   always @(posedge sclk) begin
      #1;
      if (rand_ready) m_ready = ($urandom_range(0, 9) < 6);
   end

   always @(negedge sclk) begin
      bit hs;
      hs = m_valid && m_ready;
      if (stall_prev && (!m_valid || m_data !== stall_data)) stall_err++;
      stall_prev = m_valid && !m_ready;
      stall_data = m_data;
      if (buf_rd_en) begin
         if (inflight - int'(hs) >= 2) ovf_err++;
         if (first_rden < 0) begin first_rden = cyc; first_addr = int'(buf_rd_addr); end
         rd_cnt++;
      end
      if (m_valid && first_valid < 0) first_valid = cyc;
      if (hs) begin got_q.push_back(m_data); hs_cyc_q.push_back(cyc); hs_cnt++; end
      inflight += int'(buf_rd_en) - int'(hs);
      if (buf_free) begin free_q.push_back(buf_rd_sel); free_cyc = cyc; end
      if (done_irq) begin done_cnt++; done_cyc = cyc; end
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: time limit reached before summary");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge sclk); #1; end
   endtask

   task automatic clear_model();
      exp_q.delete(); got_q.delete(); free_q.delete(); hs_cyc_q.delete();
      first_rden = -1; first_valid = -1; first_addr = -1;
      inflight = 0; stall_prev = 0;
   endtask

   task automatic pulse_start(input logic [15:0] n, input bit s, input bit a);
      blk_cnt = n; start = s; dma_auto_start = a;
      tick();
      start = 0; dma_auto_start = 0;
   endtask

   task automatic raise_block(input bit b);
      for (int i = 0; i < BUF; i++) begin
         logic [7:0] v;
         v = 8'($urandom);
         if (b) mem1[i] = v; else mem0[i] = v;
         exp_q.push_back(v);
      end
      rdy_cyc = cyc;
      if (b) buf1_rd_rdy = 1; else buf0_rd_rdy = 1;
   endtask

   task automatic serve_block(input bit b, input bit keep, input int pre_dly);
      int n0, t;
      tick(pre_dly);
      raise_block(b);
      n0 = free_q.size(); t = 0;
      while (free_q.size() == n0 && t < 20000) begin tick(); t++; end
      checks++;
      if (free_q.size() == n0) begin
         errors++;
         $display("FAIL serve_timeout: buf%0d never freed, got %0d pulses expected %0d", b, free_q.size(), n0 + 1);
      end
      if (!keep) begin if (b) buf1_rd_rdy = 0; else buf0_rd_rdy = 0; end
   endtask

   task automatic wait_done(input int d0, input string tag);
      int t = 0;
      while (done_cnt == d0 && t < 30000) begin tick(); t++; end
      checks++;
      if (done_cnt == d0) begin
         errors++;
         $display("FAIL %s_done_timeout: done_irq count %0d expected %0d", tag, done_cnt, d0 + 1);
      end
   endtask

   function automatic int stream_mm();
      int n = 0;
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
         if (got_q[i] !== exp_q[i]) n++;
      return n;
   endfunction

   function automatic int sel_mm();
      int n = 0;
      for (int i = 0; i < free_q.size(); i++)
         if (free_q[i] != bit'(i % 2)) n++;
      return n;
   endfunction

   task automatic test_reset();
      logic [39:0] ov;
      rstn = 0; srst = 0; start = 0; dma_auto_start = 0; dat_done = 0;
      buf0_rd_rdy = 0; buf1_rd_rdy = 0; m_ready = 1; blk_cnt = 16'($urandom);
      buf_rd_data = 0;
      tick(3);
      ov = {buf_free, buf_rd_en, buf_rd_sel, buf_rd_addr, m_valid, m_data, busy, done_irq, short_xfer, blk_done};
      checks++;
      if (ov !== '0) begin errors++; $display("FAIL reset_outputs: got %h expected 0", ov); end
      rstn = 1; srst = 1; start = 1;
      tick();
      start = 0; srst = 0;
      tick();
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_srst_blocks_start: busy %b expected 0", busy); end
   endtask

   task automatic test_basic();
      int d0, mm;
      clear_model();
      d0 = done_cnt;
      pulse_start(2, 1, 0);
      serve_block(0, 0, 0);
      checks++;
      if (first_rden - rdy_cyc != 1) begin errors++; $display("FAIL basic_rden_latency: got %0d expected 1", first_rden - rdy_cyc); end
      checks++;
      if (first_valid - rdy_cyc != 3) begin errors++; $display("FAIL basic_valid_latency: got %0d expected 3", first_valid - rdy_cyc); end
      serve_block(1, 0, 0);
      wait_done(d0, "basic");
      tick(2);
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL basic_len: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
      mm = stream_mm(); checks++;
      if (mm != 0) begin errors++; $display("FAIL basic_data: got %0d differing bytes expected 0", mm); end
      checks++;
      if (free_q.size() != 2 || sel_mm() != 0) begin errors++; $display("FAIL basic_free: got %0d pulses %0d wrong sel expected 2 and 0", free_q.size(), sel_mm()); end
      checks++;
      if (hs_cyc_q.size() != 2 * BUF || hs_cyc_q[BUF-1] - hs_cyc_q[0] != BUF - 1 || hs_cyc_q[2*BUF-1] - hs_cyc_q[BUF] != BUF - 1) begin
         errors++; $display("FAIL basic_rate: got %0d handshakes, block spans not %0d cycles", hs_cyc_q.size(), BUF - 1);
      end
      checks++;
      if (done_cnt - d0 != 1) begin errors++; $display("FAIL basic_irq_count: got %0d expected 1", done_cnt - d0); end
      checks++;
      if (blk_done !== 16'd2 || short_xfer !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_status: blk_done %0d short %b busy %b expected 2 0 0", blk_done, short_xfer, busy);
      end
   endtask

   task automatic test_random_stall();
      int d0, mm, s0, o0;
      clear_model();
      d0 = done_cnt; s0 = stall_err; o0 = ovf_err;
      rand_ready = 1;
      pulse_start(4, 1, 0);
      for (int k = 0; k < 4; k++) serve_block(bit'(k % 2), 0, $urandom_range(0, 15));
      wait_done(d0, "stall");
      rand_ready = 0; m_ready = 1;
      tick(2);
      checks++;
      if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL stall_len: got %0d bytes expected %0d", got_q.size(), exp_q.size()); end
      mm = stream_mm(); checks++;
      if (mm != 0) begin errors++; $display("FAIL stall_data: got %0d differing bytes expected 0", mm); end
      checks++;
      if (stall_err != s0) begin errors++; $display("FAIL stall_hold: got %0d unstable stalls expected 0", stall_err - s0); end
      checks++;
      if (ovf_err != o0) begin errors++; $display("FAIL stall_overread: got %0d reads with 2 in flight expected 0", ovf_err - o0); end
      checks++;
      if (free_q.size() != 4 || sel_mm() != 0 || blk_done !== 16'd4) begin
         errors++; $display("FAIL stall_blocks: got %0d pulses blk_done %0d expected 4 4", free_q.size(), blk_done);
      end
   endtask

   task automatic test_short();
      int d0, mm;
      clear_model();
      d0 = done_cnt;
      pulse_start(3, 1, 0);
      serve_block(0, 0, $urandom_range(0, 10));
      dat_done = 1;
      tick();
      dat_done = 0;
      wait_done(d0, "short");
      tick(2);
      checks++;
      if (done_cyc - free_cyc != HOLD + 2) begin errors++; $display("FAIL short_timing: got %0d cycles free to done expected %0d", done_cyc - free_cyc, HOLD + 2); end
      checks++;
      if (short_xfer !== 1'b1 || blk_done !== 16'd1) begin errors++; $display("FAIL short_status: short %b blk_done %0d expected 1 1", short_xfer, blk_done); end
      checks++;
      if (free_q.size() != 1 || done_cnt - d0 != 1) begin errors++; $display("FAIL short_pulses: got %0d free %0d irq expected 1 1", free_q.size(), done_cnt - d0); end
      mm = stream_mm(); checks++;
      if (got_q.size() != BUF || mm != 0) begin errors++; $display("FAIL short_data: got %0d bytes %0d differ expected %0d 0", got_q.size(), mm, BUF); end
   endtask

   task automatic test_sticky_rdy();
      int d0, r0, mm;
      clear_model();
      d0 = done_cnt;
      pulse_start(3, 0, 1);
      checks++;
      if (short_xfer !== 1'b0) begin errors++; $display("FAIL sticky_short_clear: got %b expected 0", short_xfer); end
      serve_block(0, 0, 0);
      serve_block(1, 1, 3);
      r0 = rd_cnt;
      tick(40);
      checks++;
      if (rd_cnt != r0) begin errors++; $display("FAIL sticky_reread: got %0d extra reads expected 0", rd_cnt - r0); end
      checks++;
      if (buf_rd_sel !== 1'b0 || busy !== 1'b1 || blk_done !== 16'd2) begin
         errors++; $display("FAIL sticky_wait: sel %b busy %b blk_done %0d expected 0 1 2", buf_rd_sel, busy, blk_done);
      end
      buf1_rd_rdy = 0;
      serve_block(0, 0, 2);
      wait_done(d0, "sticky");
      tick(2);
      mm = stream_mm(); checks++;
      if (got_q.size() != 3 * BUF || mm != 0) begin errors++; $display("FAIL sticky_data: got %0d bytes %0d differ expected %0d 0", got_q.size(), mm, 3 * BUF); end
      checks++;
      if (free_q.size() != 3 || sel_mm() != 0 || blk_done !== 16'd3) begin
         errors++; $display("FAIL sticky_blocks: got %0d pulses blk_done %0d expected 3 3", free_q.size(), blk_done);
      end
   endtask

   task automatic test_srst();
      int d0, h0, t, mm;
      logic [39:0] ov;
      clear_model();
      d0 = done_cnt; h0 = hs_cnt;
      pulse_start(2, 1, 0);
      raise_block(0);
      t = 0;
      while (hs_cnt - h0 < 100 && t < 5000) begin tick(); t++; end
      checks++;
      if (hs_cnt - h0 < 100) begin errors++; $display("FAIL srst_reach: got %0d bytes expected 100", hs_cnt - h0); end
      srst = 1;
      tick();
      ov = {buf_free, buf_rd_en, buf_rd_sel, buf_rd_addr, m_valid, m_data, busy, done_irq, short_xfer, blk_done};
      checks++;
      if (ov !== '0) begin errors++; $display("FAIL srst_outputs: got %h expected 0", ov); end
      srst = 0; buf0_rd_rdy = 0;
      tick(5);
      checks++;
      if (free_q.size() != 0 || done_cnt != d0) begin errors++; $display("FAIL srst_no_pulse: got %0d free %0d irq expected 0 0", free_q.size(), done_cnt - d0); end
      clear_model();
      d0 = done_cnt;
      pulse_start(1, 1, 0);
      serve_block(0, 0, 1);
      wait_done(d0, "srst");
      tick(2);
      mm = stream_mm(); checks++;
      if (got_q.size() != BUF || mm != 0 || first_addr != 0) begin
         errors++; $display("FAIL srst_restart: got %0d bytes %0d differ first addr %0d expected %0d 0 0", got_q.size(), mm, first_addr, BUF);
      end
      checks++;
      if (free_q.size() != 1 || sel_mm() != 0 || blk_done !== 16'd1) begin errors++; $display("FAIL srst_restart_free: got %0d pulses blk_done %0d expected 1 1", free_q.size(), blk_done); end
   endtask

   task automatic test_collide();
      int d0;
      clear_model();
      d0 = done_cnt;
      pulse_start(1, 1, 1);
      tick(2);
      pulse_start(5, 1, 0);
      pulse_start(5, 0, 1);
      serve_block(0, 0, 0);
      wait_done(d0, "collide");
      tick(20);
      checks++;
      if (busy !== 1'b0 || done_cnt - d0 != 1) begin errors++; $display("FAIL collide_single: busy %b irq %0d expected 0 1", busy, done_cnt - d0); end
      checks++;
      if (free_q.size() != 1 || blk_done !== 16'd1) begin errors++; $display("FAIL collide_blocks: got %0d pulses blk_done %0d expected 1 1", free_q.size(), blk_done); end
   endtask

   task automatic test_blk_zero();
      int d0, mm;
      logic [39:0] ov;
      clear_model();
      d0 = done_cnt;
      pulse_start(0, 0, 1);
      for (int k = 0; k < 3; k++) serve_block(bit'(k % 2), 0, $urandom_range(0, 8));
      tick(3);
      checks++;
      if (blk_done !== 16'd3 || busy !== 1'b1 || done_cnt != d0) begin
         errors++; $display("FAIL zero_runs_on: blk_done %0d busy %b irq %0d expected 3 1 0", blk_done, busy, done_cnt - d0);
      end
      mm = stream_mm(); checks++;
      if (got_q.size() != 3 * BUF || mm != 0) begin errors++; $display("FAIL zero_data: got %0d bytes %0d differ expected %0d 0", got_q.size(), mm, 3 * BUF); end
      @(negedge sclk);
      #2 rstn = 0;
      #1;
      ov = {buf_free, buf_rd_en, buf_rd_sel, buf_rd_addr, m_valid, m_data, busy, done_irq, short_xfer, blk_done};
      checks++;
      if (ov !== '0) begin errors++; $display("FAIL zero_async_reset: got %h expected 0", ov); end
      tick(2);
      rstn = 1;
      clear_model();
      tick(2);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random_stall();
      test_short();
      test_sticky_rdy();
      test_srst();
      test_collide();
      test_blk_zero();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sdio_dma_rd.md
Name: sdio_dma_rd

Overview:
- sys_clk-domain read-DMA engine that drains the SD receive ping-pong buffers (buf0/buf1) into a byte stream toward system memory.
- Consumes the synchronised outputs of the clock-crossing stage: the buf0/buf1 ready levels, the DMA auto-start pulse and the data-done pulse.
- Returns one buf_free pulse per drained buffer, which the crossing stage carries back to sd_clk.
- Counts blocks and raises done_irq at end of transfer.

Parameters:
BUF_BYTES, 512, bytes per buffer (block length); power of two, 4..4096
AW, 9, buffer address width, log2(BUF_BYTES)
HOLDOFF, 6, sclk cycles after buf_free before any buffer-ready level is trusted (covers the round-trip sync latency)

Ports:
sclk  in  1  system clock
rstn  in  1  asynchronous active-low reset
srst  in  1  synchronous reset, active high; same effect as rstn
start  in  1  register-write start pulse
blk_cnt  in  16  number of blocks to transfer; 0 treated as 65536
dma_auto_start  in  1  synchronised auto-start pulse from the SD side
buf0_rd_rdy  in  1  synchronised level: buf0 holds a full block
buf1_rd_rdy  in  1  synchronised level: buf1 holds a full block
dat_done  in  1  synchronised pulse: SD data phase finished
buf_free  out  1  one-cycle pulse: current buffer drained
buf_rd_en  out  1  buffer read strobe
buf_rd_sel  out  1  buffer select for reads: 0=buf0, 1=buf1
buf_rd_addr  out  AW  buffer byte address
buf_rd_data  in  8  read data, valid exactly 1 cycle after buf_rd_en
m_valid  out  1  output stream valid
m_data  out  8  output stream byte
m_ready  in  1  output stream ready
busy  out  1  high from accepted start until DONE exit
done_irq  out  1  one-cycle pulse at transfer end
short_xfer  out  1  sticky; set when dat_done ends the transfer before blk_cnt blocks; cleared on next start
blk_done  out  16  number of blocks fully drained

Behaviour:
- Reset (rstn low or srst high): state IDLE, buf_rd_sel=0, addresses and counters 0, output FIFO emptied. All outputs 0, including short_xfer and blk_done.
- srst mid-transfer aborts immediately: no buf_free pulse, no done_irq.
- States:
  - IDLE -> WAIT_RDY on start or dma_auto_start. Latch blk_cnt, clear blk_done, short_xfer, dat_done_seen and buf_rd_sel, load holdoff=0. Starts arriving while busy are ignored.
  - WAIT_RDY: the holdoff counter decrements to 0. Once it is 0:
    - ready level of the selected buffer high -> XFER; rd_left=BUF_BYTES, tx_left=BUF_BYTES, addr=0.
    - else if dat_done_seen -> DONE with short_xfer=1.
    - Ready takes priority over dat_done_seen in the same cycle.
  - XFER:
    - buf_rd_en = rd_left!=0 && (occ + rd_pend - (m_valid&m_ready)) < 2, where occ is the 2-entry output FIFO occupancy and rd_pend is a read issued last cycle. This sustains 1 byte/cycle when m_ready is held high.
    - Each rd_en increments buf_rd_addr and decrements rd_left.
    - buf_rd_data enters the FIFO the cycle after rd_en. m_valid = occ!=0; m_data = FIFO head.
    - m_valid/m_data stay stable while m_valid && !m_ready.
    - Each handshake decrements tx_left. When the last byte is accepted, go to FREE.
  - FREE (1 cycle):
    - buf_free=1, buf_rd_sel toggles, blk_done+1, holdoff=HOLDOFF.
    - If blk_done+1 == latched blk_cnt (16-bit wrap, so 0 means 65536) -> DONE, else -> WAIT_RDY.
  - DONE (1 cycle): done_irq=1, busy drops the next cycle, -> IDLE.
- dat_done_seen: set by a dat_done pulse in any busy state; ignored in IDLE.
- buf_rd_addr wraps at BUF_BYTES; rd_left and tx_left are AW+1 bits wide.
- busy=1 in WAIT_RDY, XFER, FREE and DONE.
- The buffer ready level is sampled only in WAIT_RDY and ignored elsewhere. A drop during XFER does not abort the transfer.
- Latency: from ready seen (holdoff 0) to first rd_en is 1 cycle; to first m_valid is 3 cycles.
- buf_free pulses are at least BUF_BYTES+2 cycles apart, which satisfies the toggle-sync spacing requirement.

Test Plan:
- start, blk_cnt=2, buf0 then buf1 ready, m_ready=1 -> 512 bytes per block at 1 byte/cycle in address order; 2 buf_free pulses with sel 0 then 1; done_irq once; blk_done=2; short_xfer=0.
- m_ready toggled randomly -> no byte dropped or duplicated; m_data held stable while stalled; no buf_rd_en while FIFO plus pending read equals 2.
- blk_cnt=3, only one buffer made ready, then dat_done -> DONE after holdoff; short_xfer=1; blk_done=1; exactly one buf_free.
- buf1_rd_rdy kept high through HOLDOFF after freeing buf1 -> no re-read of buf1; engine waits on buf0.
- srst asserted at byte 100 of XFER -> all outputs 0 next cycle; no buf_free; a new start runs cleanly from buf0, addr 0.
- start and dma_auto_start together, and start again while busy -> a single transfer only; blk_cnt=0 runs 65536 blocks (check wrap on a reduced-BUF_BYTES build).
